// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the byte-packing FIFO write port between two
// producers; a grant covers BURST_WORDS complete 16-bit words.
module fifo_write_arbiter #(
  parameter int unsigned BURST_WORDS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] fifo_data_in,
  output logic       fifo_input_valid,
  input  logic       fifo_input_enable,
  output logic [1:0] grant,
  output logic       busy,
  output logic [5:0] word_cnt
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [4:0] LAST_BYTE = 5'(2 * BURST_WORDS - 1);

  state_t     state, state_next;
  logic [1:0] grant_next;
  logic       rr_ptr, rr_ptr_next;
  logic [4:0] byte_cnt, byte_cnt_next;
  logic [5:0] word_cnt_next;
  logic       beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= 1'b0;
      byte_cnt <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      rr_ptr   <= rr_ptr_next;
      byte_cnt <= byte_cnt_next;
      word_cnt <= word_cnt_next;
    end
  end

  // Datapath is steered purely by the registered grant.
  always_comb begin
    fifo_data_in     = '0;
    fifo_input_valid = 1'b0;
    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    if (state == XFER) begin
      fifo_data_in     = grant[1] ? req1_data  : req0_data;
      fifo_input_valid = grant[1] ? req1_valid : req0_valid;
      req0_ready       = grant[0] & req0_valid & fifo_input_enable;
      req1_ready       = grant[1] & req1_valid & fifo_input_enable;
    end
    beat = (state == XFER) & fifo_input_valid & fifo_input_enable;
    busy = (state == XFER);
  end

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    rr_ptr_next   = rr_ptr;
    byte_cnt_next = byte_cnt;
    word_cnt_next = word_cnt;
    unique case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || !rr_ptr)) begin
          state_next    = XFER;
          grant_next    = 2'b01;
          byte_cnt_next = '0;
        end else if (req1_valid) begin
          state_next    = XFER;
          grant_next    = 2'b10;
          byte_cnt_next = '0;
        end
      end
      XFER: begin
        if (beat) begin
          byte_cnt_next = byte_cnt + 5'd1;
          if (byte_cnt[0]) word_cnt_next = word_cnt + 6'd1;
          // Pointer moves to whichever requester did not own this burst.
          if (byte_cnt == LAST_BYTE) begin
            state_next  = IDLE;
            grant_next  = '0;
            rr_ptr_next = grant[0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench: instance 0 uses BURST_WORDS=1, instance 1 uses BURST_WORDS=4.
module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_i  [2];
  logic [7:0] rdata  [4];
  logic       rvalid [4];
  logic       rready [4];
  logic [7:0] fdata  [2];
  logic       fvalid [2];
  logic       fen    [2];
  logic [1:0] gnt    [2];
  logic       bsy    [2];
  logic [5:0] wc     [2];

  logic [7:0] pq [4][$];
  logic [9:0] eq [2][$];
  logic       en      [4];
  logic       gap_arm [4];
  int         gap     [4];
  int         beats   [2];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.BURST_WORDS(1)) dut_a (
    .clk(clk), .rst(rst_i[0]),
    .req0_data(rdata[0]), .req0_valid(rvalid[0]), .req0_ready(rready[0]),
    .req1_data(rdata[1]), .req1_valid(rvalid[1]), .req1_ready(rready[1]),
    .fifo_data_in(fdata[0]), .fifo_input_valid(fvalid[0]), .fifo_input_enable(fen[0]),
    .grant(gnt[0]), .busy(bsy[0]), .word_cnt(wc[0])
  );

  fifo_write_arbiter #(.BURST_WORDS(4)) dut_b (
    .clk(clk), .rst(rst_i[1]),
    .req0_data(rdata[2]), .req0_valid(rvalid[2]), .req0_ready(rready[2]),
    .req1_data(rdata[3]), .req1_valid(rvalid[3]), .req1_ready(rready[3]),
    .fifo_data_in(fdata[1]), .fifo_input_valid(fvalid[1]), .fifo_input_enable(fen[1]),
    .grant(gnt[1]), .busy(bsy[1]), .word_cnt(wc[1])
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_beats(input int i, input int n, input string nm);
    int cyc = 0;
    while (beats[i] < n && cyc < 400) begin
      nxt();
      cyc++;
    end
    chk(nm, 64'(beats[i]), 64'(n));
  endtask

  task automatic expect_byte(input int i, input logic [1:0] own, input logic [7:0] b);
    eq[i].push_back({own, b});
  endtask

  // Producers: pop a byte one cycle after its ready was seen, optional 5-cycle gap.
  initial begin
    logic pr [4];
    forever begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) pr[p] = rready[p];
      @(posedge clk);
      #2;
      for (int p = 0; p < 4; p++) begin
        if (pr[p] === 1'b1 && pq[p].size() > 0) begin
          void'(pq[p].pop_front());
          if (gap_arm[p]) begin
            gap[p] = 5;
            gap_arm[p] = 1'b0;
          end
        end else if (gap[p] > 0) begin
          gap[p]--;
        end
        rvalid[p] = en[p] && (pq[p].size() > 0) && (gap[p] == 0);
        rdata[p]  = (pq[p].size() > 0) ? pq[p][0] : 8'h00;
      end
    end
  end

  // Monitor: every FIFO beat is matched against the scoreboard.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (fvalid[i] === 1'b1 && fen[i] === 1'b1) begin
          beats[i]++;
          if (eq[i].size() == 0) begin
            chk("unexpected_beat", {gnt[i], fdata[i]}, 64'h0);
          end else begin
            e = eq[i].pop_front();
            chk("beat", {gnt[i], fdata[i], rready[2*i+1], rready[2*i]},
                {e[9:8], e[7:0], e[9], e[8]});
          end
        end
        if (bsy[i] === 1'b1 && fen[i] === 1'b0)
          chk("stalled_ready", {rready[2*i+1], rready[2*i]}, 64'h0);
      end
    end
  end

  initial begin
    for (int p = 0; p < 4; p++) begin
      rvalid[p] = 1'b0; rdata[p] = 8'h00; en[p] = 1'b0; gap[p] = 0; gap_arm[p] = 1'b0;
    end
    rst_i[0] = 1'b1; rst_i[1] = 1'b1; fen[0] = 1'b1; fen[1] = 1'b1;
    beats[0] = 0; beats[1] = 0;

    // Reset with both requesters valid, then alternating BURST_WORDS=1 grants.
    for (int n = 0; n < 4; n++) begin
      pq[0].push_back(8'hA0 + 8'(n));
      pq[1].push_back(8'hB0 + 8'(n));
    end
    en[0] = 1'b1; en[1] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      expect_byte(0, 2'b01, 8'hA0 + 8'(2*b));
      expect_byte(0, 2'b01, 8'hA1 + 8'(2*b));
      expect_byte(0, 2'b10, 8'hB0 + 8'(2*b));
      expect_byte(0, 2'b10, 8'hB1 + 8'(2*b));
    end
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      nxt();
      chk("reset_outputs", {gnt[0], bsy[0], wc[0], fvalid[0], rready[0], rready[1]}, 64'h0);
    end
    @(posedge clk);
    #1 rst_i[0] = 1'b0;
    wait_beats(0, 6, "alt_six_beats");
    nxt();
    chk("alt_word_cnt", 64'(wc[0]), 64'd3);
    chk("alt_bubble", {gnt[0], bsy[0]}, 64'h0);
    wait_beats(0, 8, "alt_eight_beats");
    nxt();
    chk("alt_word_cnt_end", 64'(wc[0]), 64'd4);

    // Single requester: req1 gets consecutive grants with one bubble.
    en[0] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      pq[1].push_back(8'hC0 + 8'(n));
      expect_byte(0, 2'b10, 8'hC0 + 8'(n));
    end
    wait_beats(0, 10, "single_first_burst");
    nxt();
    chk("single_bubble", {gnt[0], bsy[0], rready[0]}, 64'h0);
    nxt();
    chk("single_regrant", {gnt[0], 8'(beats[0]), rready[0]}, {2'b10, 8'd11, 1'b0});
    wait_beats(0, 12, "single_done");
    nxt();
    chk("single_word_cnt", 64'(wc[0]), 64'd6);

    // Owner stalls after its first byte while req1 waits.
    pq[0].push_back(8'hD0); pq[0].push_back(8'hD1);
    pq[1].push_back(8'hE0); pq[1].push_back(8'hE1);
    expect_byte(0, 2'b01, 8'hD0); expect_byte(0, 2'b01, 8'hD1);
    expect_byte(0, 2'b10, 8'hE0); expect_byte(0, 2'b10, 8'hE1);
    gap_arm[0] = 1'b1;
    en[0] = 1'b1;
    wait_beats(0, 13, "stall_first_byte");
    for (int c = 0; c < 5; c++) begin
      nxt();
      chk("stall_hold", {gnt[0], fvalid[0], wc[0], rready[1], 8'(beats[0])},
          {2'b01, 1'b0, 6'd6, 1'b0, 8'd13});
    end
    wait_beats(0, 14, "stall_second_byte");
    nxt();
    chk("stall_word_cnt", 64'(wc[0]), 64'd7);
    wait_beats(0, 16, "stall_other_burst");
    nxt();
    chk("stall_word_cnt_end", 64'(wc[0]), 64'd8);

    // FIFO backpressure between the two bytes of a word.
    en[1] = 1'b0;
    pq[0].push_back(8'hF0); pq[0].push_back(8'hF1);
    expect_byte(0, 2'b01, 8'hF0); expect_byte(0, 2'b01, 8'hF1);
    wait_beats(0, 17, "bp_first_byte");
    @(posedge clk);
    #1 fen[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      nxt();
      chk("bp_frozen", {rready[0], rready[1], gnt[0], fvalid[0], fdata[0], wc[0], 8'(beats[0])},
          {1'b0, 1'b0, 2'b01, 1'b1, 8'hF1, 6'd8, 8'd17});
    end
    @(posedge clk);
    #1 fen[0] = 1'b1;
    wait_beats(0, 18, "bp_resume");
    nxt();
    chk("bp_word_cnt", 64'(wc[0]), 64'd9);

    // BURST_WORDS=4: 16 bursts of 8 beats, 64 words wrap word_cnt.
    en[0] = 1'b0;
    for (int n = 0; n < 64; n++) begin
      pq[2].push_back(8'(n));
      pq[3].push_back(8'h80 + 8'(n));
    end
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 8; j++)
        expect_byte(1, (k % 2) ? 2'b10 : 2'b01,
                    ((k % 2) ? 8'h80 : 8'h00) + 8'((k / 2) * 8 + j));
    en[2] = 1'b1; en[3] = 1'b1;
    nxt();
    chk("b_reset_outputs", {gnt[1], bsy[1], wc[1], fvalid[1]}, 64'h0);
    @(posedge clk);
    #1 rst_i[1] = 1'b0;
    wait_beats(1, 64, "b_half");
    nxt();
    chk("b_word_cnt_half", {bsy[1], wc[1]}, {1'b0, 6'd32});
    wait_beats(1, 128, "b_all");
    nxt();
    chk("b_word_cnt_wrap", {bsy[1], gnt[1], wc[1]}, 64'h0);

    // Reset in the middle of a burst: the beat in the reset cycle is the last.
    for (int n = 0; n < 4; n++) pq[2].push_back(8'h40 + 8'(n));
    for (int n = 0; n < 3; n++) expect_byte(1, 2'b01, 8'h40 + 8'(n));
    wait_beats(1, 130, "b_pre_reset");
    @(posedge clk);
    #1 rst_i[1] = 1'b1;
    @(posedge clk);
    #1 en[2] = 1'b0;
    nxt();
    chk("b_mid_reset", {gnt[1], bsy[1], wc[1], fvalid[1], fdata[1], rready[2], rready[3]}, 64'h0);
    @(posedge clk);
    #1 rst_i[1] = 1'b0;
    pq[2].delete();
    repeat (4) nxt();
    chk("b_after_reset", {gnt[1], bsy[1], 8'(beats[1])}, {2'b00, 1'b0, 8'd131});
    chk("scoreboard_drained", 64'(eq[0].size() + eq[1].size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
